// File: rtl/partition_stats.sv
// Partition actor: splits one buffer of 8-bit samples around a latched pivot and gathers per-partition stats.
// Latency: 1 cycle from sample accept to lower/larger valid; stats_valid pulses once both output registers drain.
// Backpressure: in_ready drops whenever a stream register is full and its consumer is not ready; nothing is dropped.
module partition_stats #(
  parameter logic [10:0] BUFF_SIZE     = 11'd1024,
  parameter int unsigned BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               in_pivot,
  input  logic [BUFF_SIZE_BIT-1:0] in_buff_size,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               lower_data,
  output logic                     lower_valid,
  input  logic                     lower_ready,
  output logic [7:0]               larger_data,
  output logic                     larger_valid,
  input  logic                     larger_ready,
  output logic [BUFF_SIZE_BIT-1:0] lower_size,
  output logic [BUFF_SIZE_BIT-1:0] equal_size,
  output logic [BUFF_SIZE_BIT-1:0] larger_size,
  output logic [8:0]               max_lower,
  output logic [8:0]               min_lower,
  output logic [8:0]               max_larger,
  output logic [8:0]               min_larger,
  output logic                     stats_valid,
  output logic                     busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // All statistics travel together so a new pass can clear them in one assignment.
  typedef struct packed {
    logic [BUFF_SIZE_BIT-1:0] lower_size;
    logic [BUFF_SIZE_BIT-1:0] equal_size;
    logic [BUFF_SIZE_BIT-1:0] larger_size;
    logic [8:0]               max_lower;
    logic [8:0]               min_lower;
    logic [8:0]               max_larger;
    logic [8:0]               min_larger;
  } stats_t;

  localparam logic [BUFF_SIZE_BIT-1:0] CNT_ONE = {{(BUFF_SIZE_BIT-1){1'b0}}, 1'b1};
  // Empty partitions report min 255 / max 0 so the next-pivot logic can spot them.
  localparam stats_t STATS_INIT = '{
    lower_size:  '0,
    equal_size:  '0,
    larger_size: '0,
    max_lower:   9'd0,
    min_lower:   9'd255,
    max_larger:  9'd0,
    min_larger:  9'd255
  };

  state_t                   state_q, state_d;
  logic [7:0]               pivot_q, pivot_d;
  logic [BUFF_SIZE_BIT-1:0] size_q, size_d;
  logic [BUFF_SIZE_BIT-1:0] count_q, count_d;
  stats_t                   stats_q, stats_d;
  logic [7:0]               lower_data_q, lower_data_d;
  logic                     lower_valid_q, lower_valid_d;
  logic [7:0]               larger_data_q, larger_data_d;
  logic                     larger_valid_q, larger_valid_d;
  logic                     stats_valid_q, stats_valid_d;
  logic                     busy_q, busy_d;
  logic                     in_ready_w;
  logic                     accept;
  logic [8:0]               sample_ext;

  // A sample may enter only when neither destination register would be overwritten while still held.
  assign in_ready_w = (state_q == S_RUN) &&
                      (!lower_valid_q  || lower_ready) &&
                      (!larger_valid_q || larger_ready);
  assign accept     = in_valid && in_ready_w;
  assign sample_ext = {1'b0, in_data};

  // Next-state logic: FSM, sample classification, stream registers and statistics.
  always_comb begin
    state_d        = state_q;
    pivot_d        = pivot_q;
    size_d         = size_q;
    count_d        = count_q;
    stats_d        = stats_q;
    lower_data_d   = lower_data_q;
    larger_data_d  = larger_data_q;
    // A consumed register empties unless the same cycle reloads it below.
    lower_valid_d  = lower_valid_q  && !lower_ready;
    larger_valid_d = larger_valid_q && !larger_ready;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pivot_d = in_pivot;
          size_d  = in_buff_size;
          count_d = '0;
          stats_d = STATS_INIT;
          state_d = (in_buff_size == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          count_d = count_q + CNT_ONE;
          if (in_data < pivot_q) begin
            lower_data_d       = in_data;
            lower_valid_d      = 1'b1;
            stats_d.lower_size = stats_q.lower_size + CNT_ONE;
            if (sample_ext > stats_q.max_lower) stats_d.max_lower = sample_ext;
            if (sample_ext < stats_q.min_lower) stats_d.min_lower = sample_ext;
          end else if (in_data > pivot_q) begin
            larger_data_d       = in_data;
            larger_valid_d      = 1'b1;
            stats_d.larger_size = stats_q.larger_size + CNT_ONE;
            if (sample_ext > stats_q.max_larger) stats_d.max_larger = sample_ext;
            if (sample_ext < stats_q.min_larger) stats_d.min_larger = sample_ext;
          end else begin
            stats_d.equal_size = stats_q.equal_size + CNT_ONE;
          end
          if (count_d == size_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!lower_valid_q && !larger_valid_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    stats_valid_d = (state_d == S_DONE);
    busy_d        = (state_d != S_IDLE);
  end

  // State registers; reset discards any pass in flight including held stream data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pivot_q        <= '0;
      size_q         <= '0;
      count_q        <= '0;
      stats_q        <= STATS_INIT;
      lower_data_q   <= '0;
      lower_valid_q  <= 1'b0;
      larger_data_q  <= '0;
      larger_valid_q <= 1'b0;
      stats_valid_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pivot_q        <= pivot_d;
      size_q         <= size_d;
      count_q        <= count_d;
      stats_q        <= stats_d;
      lower_data_q   <= lower_data_d;
      lower_valid_q  <= lower_valid_d;
      larger_data_q  <= larger_data_d;
      larger_valid_q <= larger_valid_d;
      stats_valid_q  <= stats_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign in_ready     = in_ready_w;
  assign lower_data   = lower_data_q;
  assign lower_valid  = lower_valid_q;
  assign larger_data  = larger_data_q;
  assign larger_valid = larger_valid_q;
  assign lower_size   = stats_q.lower_size;
  assign equal_size   = stats_q.equal_size;
  assign larger_size  = stats_q.larger_size;
  assign max_lower    = stats_q.max_lower;
  assign min_lower    = stats_q.min_lower;
  assign max_larger   = stats_q.max_larger;
  assign min_larger   = stats_q.min_larger;
  assign stats_valid  = stats_valid_q;
  assign busy         = busy_q;

endmodule
